sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Parametrised multi-channel bridge between the pipeline's request/acknowledge memory ports (fetch, load/store) and a single shared memory bus.
- Arbitrates NUM_CH channels and registers the winning request onto the bus.
- Tracks up to OUTSTANDING accepted-but-unanswered transactions in an in-order ID FIFO, and routes each bus response back to the channel that issued it.

Parameters:
NUM_CH, 2, number of requesting channels (index 0 = fetch, NUM_CH-1 = data)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
OUTSTANDING, 4, ID FIFO depth, power of two, >=2
FIXED_PRIO, 1, 1: highest channel index wins; 0: round robin

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
ch_req  in  NUM_CH  per-channel request valid
ch_wr  in  NUM_CH  per-channel 1=write, 0=read
ch_size  in  2*NUM_CH  per-channel size (0=byte, 1=half, 2=word)
ch_wstrb  in  NUM_CH*DATA_W/8  per-channel byte strobes
ch_addr  in  NUM_CH*ADDR_W  per-channel address
ch_wdata  in  NUM_CH*DATA_W  per-channel write data
ch_addr_ok  out  NUM_CH  request accepted (one-hot or zero)
ch_data_ok  out  NUM_CH  response for this channel (one-hot or zero)
ch_rdata  out  DATA_W  response data, broadcast to all channels
bus_req  out  1  bus request valid
bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata  out  1/2/DATA_W/8/ADDR_W/DATA_W  registered request fields
bus_addr_ok  in  1  bus accepted request
bus_data_ok  in  1  bus response valid
bus_rdata  in  DATA_W  bus response data
out_cnt  out  $clog2(OUTSTANDING)+1  FIFO occupancy
err  out  1  sticky protocol error

Behaviour:
- Reset (resetn low at posedge):
  - state=IDLE; FIFO pointers and out_cnt=0; err=0; bus_req=0; round-robin pointer=NUM_CH-1.
  - ch_addr_ok and ch_data_ok are forced to 0 combinationally whenever resetn=0.
  - Reset mid-operation drops the held request and all outstanding IDs.
- State IDLE:
  - room = (out_cnt < OUTSTANDING).
  - If room and any ch_req: grant one channel g.
    - FIXED_PRIO=1: highest set index wins.
    - FIXED_PRIO=0: first set index after the last grant, wrapping.
  - ch_addr_ok[g]=1 in that same cycle (combinational).
  - At the edge: capture g's fields into the bus registers, store id=g, update the round-robin pointer, go REQ.
  - If no room: no grant, ch_addr_ok=0, stay IDLE.
- State REQ:
  - bus_req=1; the registered fields stay stable.
  - On bus_addr_ok: push id into the FIFO, go IDLE.
  - No new grant is made in REQ, so throughput is at most one request per 2 cycles.
- Response path:
  - hit = bus_data_ok & (out_cnt!=0).
  - ch_data_ok[fifo_head]=hit (combinational); ch_rdata=bus_rdata.
  - Pop on hit.
  - bus_data_ok with out_cnt==0: no ch_data_ok, err<=1 (sticky until reset).
- Simultaneous push and pop: out_cnt unchanged; a pop of the head never returns the entry being pushed in the same cycle.
- Occupancy:
  - out_cnt counts FIFO entries only; the held REQ entry is not counted.
  - A push occurs only if room held at grant time, so with OUTSTANDING entries no overflow occurs.
- Response ordering: in order of bus acceptance, independent of channel.
- Pointer arithmetic: FIFO pointers are $clog2(OUTSTANDING) bits and wrap modulo OUTSTANDING.

Test Plan:
- Single read: ch_req[0]=1, addr=0x1C000000 in IDLE -> ch_addr_ok=01 that cycle; next cycle bus_req=1, bus_addr=0x1C000000. bus_addr_ok -> out_cnt=1. bus_data_ok with rdata=0xDEADBEEF -> ch_data_ok=01, ch_rdata=0xDEADBEEF, out_cnt=0.
- Priority, FIXED_PRIO=1: ch_req=11 held -> every grant goes to channel 1 (data). With FIXED_PRIO=0 the grants alternate 1,0,1,0 (starting from pointer NUM_CH-1, index 0 first after wrap, so actually 0,1,0,1).
- Backpressure, OUTSTANDING=2: two accepted with no responses -> out_cnt=2, third ch_req gets ch_addr_ok=0. One bus_data_ok -> the next IDLE cycle grants.
- Simultaneous push/pop: bus_addr_ok and bus_data_ok in the same cycle with out_cnt=1 -> out_cnt stays 1, ch_data_ok goes to the older ID.
- Spurious response: bus_data_ok with out_cnt=0 -> ch_data_ok=00, err=1 and held. resetn=0 -> err=0.
- Reset mid-op: resetn=0 while in REQ with out_cnt=3 -> next cycle bus_req=0, out_cnt=0. A subsequent bus_data_ok sets err.

Source files
------------

// File: rtl/sram_like_arbiter_if.sv
// Request/acknowledge memory port bundle, N lanes wide (N=1 for the shared bus).
// Pure wiring, no latency.
// Backpressure: addr_ok accepts a request, data_ok returns its response.
interface sram_like_arbiter_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Request side, per lane.
  logic [N-1:0]          req;
  logic [N-1:0]          wr;
  logic [2*N-1:0]        size;
  logic [N*DATA_W/8-1:0] wstrb;
  logic [N*ADDR_W-1:0]   addr;
  logic [N*DATA_W-1:0]   wdata;
  // Acknowledge / response side. rdata is shared by every lane.
  logic [N-1:0]          addr_ok;
  logic [N-1:0]          data_ok;
  logic [DATA_W-1:0]     rdata;

  // The side that issues requests.
  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  // The side that serves requests.
  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Arbitrates NUM_CH request/ack channels onto one bus and routes responses back in order.
// Latency: grant is combinational, the bus request is registered one cycle later.
// Backpressure: grants stop when OUTSTANDING IDs wait for responses; the held bus request waits for bus addr_ok.
module sram_like_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 4,
  parameter int FIXED_PRIO  = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  sram_like_arbiter_if.slave           ch,
  sram_like_arbiter_if.master          bus,
  output logic [$clog2(OUTSTANDING):0] out_cnt,
  output logic                         err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(OUTSTANDING);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  // Controller state.
  logic [0:0]        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  // Registered bus request, held stable while in REQ.
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ID_W-1:0]   id_q, id_d;

  // In-order ID FIFO of accepted-but-unanswered transactions.
  logic [ID_W-1:0]   fifo_q [OUTSTANDING];
  logic [ID_W-1:0]   fifo_d [OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              err_q, err_d;

  // Datapath / handshake helpers.
  logic              room;
  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_id;
  logic              rr_found;
  int                rr_idx;
  logic              push;
  logic              hit;
  logic [ID_W-1:0]   head_id;

  // Channel selection: fixed priority scans upward so the highest requester wins,
  // round robin takes the first requester after the previous winner.
  always_comb begin
    gnt_id   = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    if (FIXED_PRIO != 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch.req[i]) begin
          gnt_id = ID_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        rr_idx = (int'(rr_ptr_q) + k) % NUM_CH;
        if (!rr_found && ch.req[rr_idx]) begin
          gnt_id   = ID_W'(rr_idx);
          rr_found = 1'b1;
        end
      end
    end
  end

  // Grant and response qualification; reset masks both acknowledges.
  always_comb begin
    room    = (out_cnt_q < CNT_W'(OUTSTANDING));
    gnt_vld = resetn && (state_q == ST_IDLE) && room && (|ch.req);
    push    = (state_q == ST_REQ) && bus.addr_ok[0];
    hit     = bus.data_ok[0] && (out_cnt_q != '0);
    head_id = fifo_q[rd_ptr_q];
  end

  // Channel-facing outputs.
  always_comb begin
    ch.addr_ok = '0;
    ch.data_ok = '0;
    if (gnt_vld) begin
      ch.addr_ok = NUM_CH'(1) << gnt_id;
    end
    if (resetn && hit) begin
      ch.data_ok = NUM_CH'(1) << head_id;
    end
    ch.rdata = bus.rdata;
  end

  // Bus-facing outputs come straight from the request registers.
  always_comb begin
    bus.req   = (state_q == ST_REQ);
    bus.wr    = wr_q;
    bus.size  = size_q;
    bus.wstrb = wstrb_q;
    bus.addr  = addr_q;
    bus.wdata = wdata_q;
    out_cnt   = out_cnt_q;
    err       = err_q;
  end

  // Request FSM: capture the winner in IDLE, hold it on the bus until accepted.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    wr_d     = wr_q;
    size_d   = size_q;
    wstrb_d  = wstrb_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    id_d     = id_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          wr_d     = ch.wr[gnt_id];
          size_d   = ch.size[int'(gnt_id)*2 +: 2];
          wstrb_d  = ch.wstrb[int'(gnt_id)*STRB_W +: STRB_W];
          addr_d   = ch.addr[int'(gnt_id)*ADDR_W +: ADDR_W];
          wdata_d  = ch.wdata[int'(gnt_id)*DATA_W +: DATA_W];
          id_d     = gnt_id;
          rr_ptr_d = gnt_id;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.addr_ok[0]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ID FIFO bookkeeping. The head is read from stored entries only, so an ID
  // pushed this cycle can never answer a response arriving in the same cycle.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = id_q;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (hit) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, hit})
      2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
      2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
    // A response with nothing outstanding is a bus protocol violation.
    err_d = err_q | (bus.data_ok[0] && (out_cnt_q == '0));
  end

  // State registers; reset drops the held request and every outstanding ID.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= ID_W'(NUM_CH - 1);
      wr_q      <= 1'b0;
      size_q    <= '0;
      wstrb_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      id_q      <= '0;
      fifo_q    <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      id_q      <= id_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: two arbiters share one stimulus stream.
// u_a: fixed priority, 4 outstanding. u_b: round robin, 2 outstanding.
// Checks are made 1 time unit after inputs settle, or 1 unit after a clock edge.
module tb_sram_like_arbiter;

  logic        clk;
  logic        resetn;
  logic [1:0]  req;
  logic [1:0]  wr;
  logic [3:0]  size;
  logic [7:0]  wstrb;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        b_addr_ok;
  logic        b_data_ok;
  logic [31:0] b_rdata;
  logic [2:0]  cnt_a;
  logic [1:0]  cnt_b;
  logic        err_a;
  logic        err_b;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;

  sram_like_arbiter_if #(.N(2), .ADDR_W(32), .DATA_W(32)) ch_a ();
  sram_like_arbiter_if #(.N(2), .ADDR_W(32), .DATA_W(32)) ch_b ();
  sram_like_arbiter_if #(.N(1), .ADDR_W(32), .DATA_W(32)) bus_a ();
  sram_like_arbiter_if #(.N(1), .ADDR_W(32), .DATA_W(32)) bus_b ();

  assign ch_a.req   = req;   assign ch_b.req   = req;
  assign ch_a.wr    = wr;    assign ch_b.wr    = wr;
  assign ch_a.size  = size;  assign ch_b.size  = size;
  assign ch_a.wstrb = wstrb; assign ch_b.wstrb = wstrb;
  assign ch_a.addr  = addr;  assign ch_b.addr  = addr;
  assign ch_a.wdata = wdata; assign ch_b.wdata = wdata;
  assign bus_a.addr_ok = b_addr_ok; assign bus_b.addr_ok = b_addr_ok;
  assign bus_a.data_ok = b_data_ok; assign bus_b.data_ok = b_data_ok;
  assign bus_a.rdata   = b_rdata;   assign bus_b.rdata   = b_rdata;

  sram_like_arbiter #(
    .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .OUTSTANDING(4), .FIXED_PRIO(1)
  ) u_a (
    .clk(clk), .resetn(resetn), .ch(ch_a), .bus(bus_a), .out_cnt(cnt_a), .err(err_a)
  );

  sram_like_arbiter #(
    .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .OUTSTANDING(2), .FIXED_PRIO(0)
  ) u_b (
    .clk(clk), .resetn(resetn), .ch(ch_b), .bus(bus_b), .out_cnt(cnt_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected grants while both channels request and the bus accepts at once.
  logic [1:0] exp_ga [6] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  logic [1:0] exp_gb [6] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    resetn = 1'b0; req = '0; wr = '0; size = '0; wstrb = '0; addr = '0; wdata = '0;
    b_addr_ok = 1'b0; b_data_ok = 1'b0; b_rdata = '0;
    step();

    // Reset masks acknowledges even with a request pending.
    req = 2'b01; b_data_ok = 1'b1; settle();
    chk_eq("rst_addr_ok_a", 64'(ch_a.addr_ok), 64'h0);
    chk_eq("rst_addr_ok_b", 64'(ch_b.addr_ok), 64'h0);
    step();
    req = 2'b00; b_data_ok = 1'b0; resetn = 1'b1; settle();
    chk_eq("rst_bus_req_a", 64'(bus_a.req), 64'h0);
    chk_eq("rst_cnt_a", 64'(cnt_a), 64'h0);
    chk_eq("rst_err_a", 64'(err_a), 64'h0);
    chk_eq("rst_cnt_b", 64'(cnt_b), 64'h0);
    chk_eq("rst_err_b", 64'(err_b), 64'h0);

    // Single read from channel 0.
    addr = {32'h0, 32'h1C00_0000}; size = 4'b0010; wstrb = 8'h0F; req = 2'b01; settle();
    chk_eq("rd_addr_ok_a", 64'(ch_a.addr_ok), 64'h1);
    chk_eq("rd_addr_ok_b", 64'(ch_b.addr_ok), 64'h1);
    step();
    req = 2'b00;
    chk_eq("rd_bus_req_a", 64'(bus_a.req), 64'h1);
    chk_eq("rd_bus_addr_a", 64'(bus_a.addr), 64'h1C00_0000);
    chk_eq("rd_bus_addr_b", 64'(bus_b.addr), 64'h1C00_0000);
    chk_eq("rd_bus_wr_a", 64'(bus_a.wr), 64'h0);
    chk_eq("rd_bus_size_a", 64'(bus_a.size), 64'h2);
    b_addr_ok = 1'b1; step(); b_addr_ok = 1'b0;
    chk_eq("rd_cnt_a", 64'(cnt_a), 64'h1);
    chk_eq("rd_cnt_b", 64'(cnt_b), 64'h1);
    chk_eq("rd_bus_req_low_a", 64'(bus_a.req), 64'h0);
    b_data_ok = 1'b1; b_rdata = 32'hDEAD_BEEF; settle();
    chk_eq("rd_data_ok_a", 64'(ch_a.data_ok), 64'h1);
    chk_eq("rd_data_ok_b", 64'(ch_b.data_ok), 64'h1);
    chk_eq("rd_rdata_a", 64'(ch_a.rdata), 64'hDEAD_BEEF);
    step(); b_data_ok = 1'b0;
    chk_eq("rd_cnt0_a", 64'(cnt_a), 64'h0);
    chk_eq("rd_cnt0_b", 64'(cnt_b), 64'h0);

    // Both channels request; ch1 is a half-word write. u_b stalls once full.
    addr = {32'h2000_0000, 32'h1000_0000}; wdata = {32'hCAFE_F00D, 32'h1234_5678};
    wr = 2'b10; size = 4'b0110; wstrb = 8'hCF; req = 2'b11; b_addr_ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      chk_eq($sformatf("prio_gnt_a_%0d", c), 64'(ch_a.addr_ok), 64'(exp_ga[c]));
      chk_eq($sformatf("prio_gnt_b_%0d", c), 64'(ch_b.addr_ok), 64'(exp_gb[c]));
      step();
      if (c == 0) begin
        chk_eq("wr_bus_wr_a", 64'(bus_a.wr), 64'h1);
        chk_eq("wr_bus_wdata_a", 64'(bus_a.wdata), 64'hCAFE_F00D);
        chk_eq("wr_bus_wstrb_a", 64'(bus_a.wstrb), 64'hC);
        chk_eq("wr_bus_size_a", 64'(bus_a.size), 64'h1);
        chk_eq("wr_bus_addr_b", 64'(bus_b.addr), 64'h2000_0000);
      end
      if (c == 2) begin
        chk_eq("rr_bus_addr_b", 64'(bus_b.addr), 64'h1000_0000);
        chk_eq("rr_bus_wr_b", 64'(bus_b.wr), 64'h0);
        chk_eq("fp_bus_addr_a", 64'(bus_a.addr), 64'h2000_0000);
      end
    end
    req = 2'b00; b_addr_ok = 1'b0; wr = 2'b00;
    chk_eq("prio_cnt_a", 64'(cnt_a), 64'h3);
    chk_eq("full_cnt_b", 64'(cnt_b), 64'h2);

    // One response frees a slot; u_b grants on its next IDLE cycle.
    req = 2'b01; b_data_ok = 1'b1; b_rdata = 32'hA5A5_0001; settle();
    chk_eq("bp_gnt_a", 64'(ch_a.addr_ok), 64'h1);
    chk_eq("bp_gnt_b", 64'(ch_b.addr_ok), 64'h0);
    chk_eq("resp0_a", 64'(ch_a.data_ok), 64'h2);
    chk_eq("resp0_b", 64'(ch_b.data_ok), 64'h2);
    step();
    chk_eq("resp0_cnt_a", 64'(cnt_a), 64'h2);
    chk_eq("resp0_cnt_b", 64'(cnt_b), 64'h1);
    b_data_ok = 1'b0; settle();
    chk_eq("held_gnt_a", 64'(ch_a.addr_ok), 64'h0);
    chk_eq("bp_regnt_b", 64'(ch_b.addr_ok), 64'h1);
    step(); req = 2'b00;
    chk_eq("bp_bus_req_b", 64'(bus_b.req), 64'h1);

    // Push and pop in the same cycle: count unchanged, older ID answered.
    b_addr_ok = 1'b1; b_data_ok = 1'b1; settle();
    chk_eq("pp_resp_a", 64'(ch_a.data_ok), 64'h2);
    chk_eq("pp_resp_b", 64'(ch_b.data_ok), 64'h1);
    step(); b_addr_ok = 1'b0;
    chk_eq("pp_cnt_a", 64'(cnt_a), 64'h2);
    chk_eq("pp_cnt_b", 64'(cnt_b), 64'h1);
    settle();
    chk_eq("drain1_a", 64'(ch_a.data_ok), 64'h2);
    chk_eq("drain1_b", 64'(ch_b.data_ok), 64'h1);
    step();
    chk_eq("drain1_cnt_a", 64'(cnt_a), 64'h1);
    chk_eq("drain1_cnt_b", 64'(cnt_b), 64'h0);
    settle();
    chk_eq("drain2_a", 64'(ch_a.data_ok), 64'h1);
    chk_eq("spur_resp_b", 64'(ch_b.data_ok), 64'h0);
    step();
    chk_eq("drain2_cnt_a", 64'(cnt_a), 64'h0);
    chk_eq("drain2_err_a", 64'(err_a), 64'h0);
    chk_eq("spur_err_b", 64'(err_b), 64'h1);
    settle();
    chk_eq("spur_resp_a", 64'(ch_a.data_ok), 64'h0);
    step(); b_data_ok = 1'b0;
    chk_eq("spur_err_a", 64'(err_a), 64'h1);
    step();
    chk_eq("err_held_a", 64'(err_a), 64'h1);
    chk_eq("err_held_b", 64'(err_b), 64'h1);

    // Reset clears the sticky error.
    resetn = 1'b0; step(); resetn = 1'b1;
    chk_eq("err_clr_a", 64'(err_a), 64'h0);
    chk_eq("err_clr_b", 64'(err_b), 64'h0);

    // Build three outstanding plus a held request on u_a, then reset mid-operation.
    req = 2'b10; b_addr_ok = 1'b1;
    repeat (6) step();
    b_addr_ok = 1'b0; step(); req = 2'b00;
    chk_eq("mid_bus_req_a", 64'(bus_a.req), 64'h1);
    chk_eq("mid_cnt_a", 64'(cnt_a), 64'h3);
    resetn = 1'b0; b_data_ok = 1'b1; settle();
    chk_eq("mid_rst_resp_a", 64'(ch_a.data_ok), 64'h0);
    step(); resetn = 1'b1; b_data_ok = 1'b0;
    chk_eq("mid_rst_bus_req_a", 64'(bus_a.req), 64'h0);
    chk_eq("mid_rst_cnt_a", 64'(cnt_a), 64'h0);
    chk_eq("mid_rst_err_a", 64'(err_a), 64'h0);
    b_data_ok = 1'b1; settle();
    chk_eq("post_rst_resp_a", 64'(ch_a.data_ok), 64'h0);
    step(); b_data_ok = 1'b0;
    chk_eq("post_rst_err_a", 64'(err_a), 64'h1);
    chk_eq("post_rst_err_b", 64'(err_b), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
